// File: rtl/c2_bus_master.sv
// Cache-side master for the C2 memory bus: turns one 16-byte line request into
// an 8-beat WRITE_LINE, or a READ_LINE / RESPONSE exchange, and reports completion.
module c2_bus_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [15:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  output logic         resp_error,
  output logic [127:0] resp_rdata,
  output logic [15:0]  c2_addr,
  inout  wire  [15:0]  c2_data,
  inout  wire  [1:0]   c2_cmd
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CmdNop   = 2'b00;
  localparam logic [1:0] CmdResp  = 2'b01;
  localparam logic [1:0] CmdRead  = 2'b10;
  localparam logic [1:0] CmdWrite = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdCmd,
    StRdWait,
    StRdBeat,
    StTurn
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic           err_q, err_d;
  logic [15:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [127:0]   rbuf_q, rbuf_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_error_q, resp_error_d;

  logic           own;
  logic [1:0]     cmd_drv;
  logic [15:0]    data_drv;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    own          = 1'b1;
    cmd_drv      = CmdNop;
    data_drv     = 16'h0000;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 3'd0;
          err_d   = 1'b0;
          state_d = req_write ? StWr : StRdCmd;
        end
      end
      StWr: begin
        cmd_drv  = CmdWrite;
        data_drv = wdata_q[{cnt_q, 4'b0000} +: 16];
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d      = StIdle;
          resp_valid_d = 1'b1;
        end
      end
      StRdCmd: begin
        cmd_drv = CmdRead;
        tmo_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        own = 1'b0;
        if (c2_cmd == CmdResp) begin
          cnt_d   = 3'd0;
          state_d = StRdBeat;
        end else begin
          // Saturating so a large TIMEOUT can never alias back to zero.
          if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
          if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end
        end
      end
      StRdBeat: begin
        own = 1'b0;
        rbuf_d[{cnt_q, 4'b0000} +: 16] = c2_data;
        if (c2_cmd != CmdResp) err_d = 1'b1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StTurn;
      end
      StTurn: begin
        own          = 1'b0;
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_error_d = err_q;
        if (!err_q) rdata_d = rbuf_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = rdata_q;
  assign c2_addr    = addr_q;
  assign c2_cmd     = own ? cmd_drv : 2'bzz;
  assign c2_data    = own ? data_drv : 16'hzzzz;

endmodule

// File: tb/tb_c2_bus_master.sv
// Bench for c2_bus_master: a scripted C2 memory/responder plus a cycle table for
// the write path and hand-written read, timeout, protocol-error and reset sequences.
module tb_c2_bus_master;

  localparam int unsigned TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_error;
  logic [127:0] resp_rdata;
  logic [15:0]  c2_addr;
  wire  [15:0]  c2_data;
  wire  [1:0]   c2_cmd;

  c2_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .resp_rdata (resp_rdata),
    .c2_addr    (c2_addr),
    .c2_data    (c2_data),
    .c2_cmd     (c2_cmd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: stores written lines, answers READ_LINE after resp_delay cycles.
  logic [127:0] mem [16];
  logic [2:0]   wb;
  logic [1:0]   mst;
  int           mcnt;
  logic [2:0]   mb;
  logic [15:0]  raddr;
  bit           en_resp;
  int           resp_delay;
  int           drop_beat;
  logic         mem_drv;
  logic [1:0]   mem_cmd;
  logic [15:0]  mem_data;

  always @(posedge clk) begin
    if (reset) begin
      wb   <= 3'd0;
      mst  <= 2'd0;
      mcnt <= 0;
      mb   <= 3'd0;
    end else begin
      if (c2_cmd == 2'b11) begin
        mem[c2_addr[3:0]][{wb, 4'b0000} +: 16] <= c2_data;
        wb <= wb + 3'd1;
      end else begin
        wb <= 3'd0;
      end
      case (mst)
        2'd0: if (en_resp && c2_cmd == 2'b10) begin
          raddr <= c2_addr;
          if (resp_delay == 0) mst <= 2'd2;
          else begin
            mst  <= 2'd1;
            mcnt <= resp_delay - 1;
          end
        end
        2'd1: if (mcnt == 0) mst <= 2'd2; else mcnt <= mcnt - 1;
        2'd2: begin
          mst <= 2'd3;
          mb  <= 3'd0;
        end
        default: begin
          mb <= mb + 3'd1;
          if (mb == 3'd7) mst <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    mem_drv  = (mst == 2'd2) || (mst == 2'd3);
    mem_cmd  = ((mst == 2'd3) && (int'(mb) == drop_beat)) ? 2'b00 : 2'b01;
    mem_data = 16'h0000;
    if (mst == 2'd3) mem_data = mem[raddr[3:0]][{mb, 4'b0000} +: 16];
  end

  assign c2_cmd  = mem_drv ? mem_cmd : 2'bzz;
  assign c2_data = mem_drv ? mem_data : 16'hzzzz;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called in the cycle after acceptance (latency 1); returns the latency of resp_valid.
  task automatic wait_resp(input int max_cyc, output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < max_cyc) begin
      tick();
      lat++;
    end
    chk("resp_seen", 128'(resp_valid), 128'(1'b1));
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [127:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        rv_in;
    logic        wr_in;
    logic [15:0] addr_in;
    logic [1:0]  e_cmd;
    logic [15:0] e_data;
    logic [15:0] e_addr;
    logic        e_ready;
    logic        e_rvalid;
    logic        e_rerr;
  } vec_t;

  vec_t         tbl [11];
  logic [127:0] line3;
  logic [127:0] line5;
  int           lat;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = '0;
    en_resp    = 1'b1;
    resp_delay = 0;
    drop_beat  = -1;
    for (int b = 0; b < 16; b++) begin
      line3[8*b +: 8] = 8'(b);
      line5[8*b +: 8] = 8'(b * 17 + 1);
    end

    // Write addr 3, one row per cycle starting at the acceptance cycle.
    tbl[0] = '{1'b1, 1'b1, 16'd3, 2'b00, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0};
    for (int k = 1; k <= 8; k++)
      tbl[k] = '{1'b0, 1'b0, 16'd0, 2'b11, {8'(2*k-1), 8'(2*k-2)}, 16'd3, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'd0, 2'b00, 16'h0000, 16'd3, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'd0, 2'b00, 16'h0000, 16'd3, 1'b1, 1'b0, 1'b0};

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_rdata", resp_rdata, 128'h0);
    chk("rst_rerr", 128'(resp_error), 128'h0);

    req_wdata = line3;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("wr[%0d].cmd", i), 128'(c2_cmd), 128'(tbl[i].e_cmd));
      chk($sformatf("wr[%0d].data", i), 128'(c2_data), 128'(tbl[i].e_data));
      chk($sformatf("wr[%0d].addr", i), 128'(c2_addr), 128'(tbl[i].e_addr));
      chk($sformatf("wr[%0d].ready", i), 128'(req_ready), 128'(tbl[i].e_ready));
      chk($sformatf("wr[%0d].rvalid", i), 128'(resp_valid), 128'(tbl[i].e_rvalid));
      chk($sformatf("wr[%0d].rerr", i), 128'(resp_error), 128'(tbl[i].e_rerr));
      req_valid = tbl[i].rv_in;
      req_write = tbl[i].wr_in;
      req_addr  = tbl[i].addr_in;
      tick();
    end

    // Read addr 3; RESPONSE at the last cycle before timeout (R = T+5).
    resp_delay = 3;
    issue(1'b0, 16'd3, '0);
    chk("rd.cmd", 128'(c2_cmd), 128'(2'b10));
    chk("rd.addr", 128'(c2_addr), 128'd3);
    chk("rd.ready", 128'(req_ready), 128'h0);
    wait_resp(40, lat);
    chk("rd.lat", 128'(lat), 128'd15);
    chk("rd.rerr", 128'(resp_error), 128'h0);
    chk("rd.rdata", resp_rdata, line3);
    tick();
    chk("rd.hold", resp_rdata, line3);
    chk("rd.pulse", 128'(resp_valid), 128'h0);

    // Back-to-back write addr 5 then read addr 5 with req_valid held.
    resp_delay = 0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 16'd5;
    req_wdata  = line5;
    tick();
    chk("b2b.wcmd", 128'(c2_cmd), 128'(2'b11));
    chk("b2b.wready", 128'(req_ready), 128'h0);
    wait_resp(20, lat);
    chk("b2b.wlat", 128'(lat), 128'd9);
    chk("b2b.wready9", 128'(req_ready), 128'h1);
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("b2b.rcmd", 128'(c2_cmd), 128'(2'b10));
    chk("b2b.raddr", 128'(c2_addr), 128'd5);
    wait_resp(40, lat);
    chk("b2b.rlat", 128'(lat), 128'd12);
    chk("b2b.rerr", 128'(resp_error), 128'h0);
    chk("b2b.rdata", resp_rdata, line5);
    tick();

    // No responder: timeout after TIMEOUT cycles in RD_WAIT.
    en_resp = 1'b0;
    issue(1'b0, 16'd3, '0);
    wait_resp(20, lat);
    chk("tmo.lat", 128'(lat), 128'(TIMEOUT + 2));
    chk("tmo.rerr", 128'(resp_error), 128'h1);
    chk("tmo.rdata", resp_rdata, line5);
    tick();
    en_resp = 1'b1;

    // Responder drops to NOP on beat 4.
    drop_beat = 4;
    issue(1'b0, 16'd3, '0);
    wait_resp(40, lat);
    chk("drop.lat", 128'(lat), 128'd12);
    chk("drop.rerr", 128'(resp_error), 128'h1);
    chk("drop.rdata", resp_rdata, line5);
    tick();
    drop_beat = -1;

    // Reset during the 3rd WR cycle.
    issue(1'b1, 16'd7, line5);
    tick();
    tick();
    chk("rst3.cmd", 128'(c2_cmd), 128'(2'b11));
    chk("rst3.data", 128'(c2_data), 128'(line5[47:32]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw.cmd", 128'(c2_cmd), 128'(2'b00));
    chk("rstw.data", 128'(c2_data), 128'h0);
    chk("rstw.ready", 128'(req_ready), 128'h1);
    chk("rstw.rvalid", 128'(resp_valid), 128'h0);
    chk("rstw.rdata", resp_rdata, 128'h0);
    tick();
    chk("rstw.rvalid2", 128'(resp_valid), 128'h0);

    resp_delay = 1;
    issue(1'b0, 16'd3, '0);
    wait_resp(40, lat);
    chk("post.lat", 128'(lat), 128'd13);
    chk("post.rerr", 128'(resp_error), 128'h0);
    chk("post.rdata", resp_rdata, line3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
